// File: rtl/spi_shift_unit.sv
// spi_shift_unit: SPI slave shift engine; transmit path present when SPI_SHIFT_UNIT_TX_EN is defined.
module spi_shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_cond,
  input  logic             sclk_pos,
  input  logic             sclk_neg,
  input  logic             mosi_cond,
  input  logic             rx_ack,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             overrun,
  output logic             miso,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic             state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_sr;
  logic             start, cap, done, shl;
  assign busy  = state == SHIFT;
  assign start = ~busy & ~cs_cond;
  assign cap   = busy & ~cs_cond & sclk_pos;
  assign done  = cap & (bit_cnt == CW'(WIDTH - 1));
  assign shl   = busy & ~cs_cond & ~sclk_pos & sclk_neg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= cs_cond ? IDLE : SHIFT;
      if (start) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (cap) begin
        rx_sr   <= {rx_sr[WIDTH-2:0], mosi_cond};
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
      end
      // a completing word outranks a coincident acknowledge
      if (done) begin
        rx_data  <= {rx_sr[WIDTH-2:0], mosi_cond};
        rx_valid <= 1'b1;
        overrun  <= overrun | (rx_valid & ~rx_ack);
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end
`ifdef SPI_SHIFT_UNIT_TX_EN
  logic [WIDTH-1:0] tx_buf, tx_sr;
  logic [WIDTH-1:0] tx_next;
  assign tx_next = tx_load ? tx_data : tx_buf;
  assign miso    = busy & tx_sr[WIDTH-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf <= '0;
      tx_sr  <= '0;
    end else begin
      if (tx_load) tx_buf <= tx_data;
      if (start || done) tx_sr <= tx_next;
      else if (shl) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
    end
  end
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_load, shl};
  assign miso      = 1'b0;
`endif
endmodule
